// File: rtl/iobuf_turnaround_ctrl_pkg.sv
// rtl/iobuf_turnaround_ctrl_pkg.sv - shared state encoding and counter sizing for the pad turnaround controller
package iobuf_ctrl_pkg;

   typedef logic [1:0] state_t;

   localparam state_t ST_IDLE  = 2'd0;
   localparam state_t ST_DRIVE = 2'd1;
   localparam state_t ST_TURN  = 2'd2;

   // Bits needed to hold the values 0..maxval inclusive.
   function automatic int cnt_width(input int maxval);
      return (maxval < 1) ? 1 : $clog2(maxval + 1);
   endfunction

endpackage

// File: rtl/iobuf_turnaround_ctrl_if.sv
// rtl/iobuf_turnaround_ctrl_if.sv - requester, pad buffer and receive signals of the turnaround controller
interface iobuf_turnaround_ctrl_if #(
   parameter int WIDTH = 8,
   parameter int NREQ  = 2
);
   logic [NREQ-1:0]       REQ;
   logic [NREQ*WIDTH-1:0] DIN;
   logic [NREQ-1:0]       GNT;
   logic [WIDTH-1:0]      PAD_I;
   logic                  PAD_T;
   logic [WIDTH-1:0]      PAD_O;
   logic [WIDTH-1:0]      RX_DATA;
   logic                  RX_VALID;

   modport slave (
      input  REQ, DIN, PAD_O,
      output GNT, PAD_I, PAD_T, RX_DATA, RX_VALID
   );

   modport master (
      output REQ, DIN, PAD_O,
      input  GNT, PAD_I, PAD_T, RX_DATA, RX_VALID
   );
endinterface

// File: rtl/iobuf_turnaround_ctrl_rr_arbiter.sv
// rtl/iobuf_turnaround_ctrl_rr_arbiter.sv - combinational round-robin pick starting at the pointer
module rr_arbiter #(
   parameter int NREQ = 2,
   parameter int PW   = 1
) (
   input  logic [NREQ-1:0] i_req,
   input  logic [PW-1:0]   i_ptr,
   output logic [NREQ-1:0] o_gnt,
   output logic [PW-1:0]   o_idx,
   output logic            o_any
);
   always_comb begin
      int   j;
      logic found;
      j     = 0;
      found = 1'b0;
      o_gnt = '0;
      o_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         j = (int'(i_ptr) + k) % NREQ;
         if (!found && i_req[j]) begin
            found    = 1'b1;
            o_idx    = PW'(j);
            o_gnt    = '0;
            o_gnt[j] = 1'b1;
         end
      end
      o_any = found;
   end
endmodule

// File: rtl/iobuf_turnaround_ctrl.sv
// rtl/iobuf_turnaround_ctrl.sv - arbitrates requesters onto a tristate pad group with forced high-Z turnaround
module iobuf_turnaround_ctrl
   import iobuf_ctrl_pkg::*;
#(
   parameter int WIDTH    = 8,
   parameter int NREQ     = 2,
   parameter int MAXBURST = 4,
   parameter int TURN     = 1
) (
   input  logic                    CLK,
   input  logic                    CLR,
   iobuf_turnaround_ctrl_if.slave  bus
);
   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int BW = cnt_width(MAXBURST);
   localparam int TW = cnt_width(TURN);

   state_t           r_state;
   logic [NREQ-1:0]  r_gnt;
   logic [PW-1:0]    r_gidx;
   logic [PW-1:0]    r_ptr;
   logic [BW-1:0]    r_beat;
   logic [TW-1:0]    r_turn;
   logic [WIDTH-1:0] r_pad_i;
   logic             r_pad_t;
   logic [WIDTH-1:0] r_rx_data;
   logic             r_rx_valid;

   logic [NREQ-1:0]  w_arb_gnt;
   logic [PW-1:0]    w_arb_idx;
   logic             w_arb_any;
   logic [PW-1:0]    w_ptr_next;
   logic             w_req_g;
   logic [WIDTH-1:0] w_din_g;
   logic [BW-1:0]    w_beat_next;

   rr_arbiter #(
      .NREQ (NREQ),
      .PW   (PW)
   ) u_arb (
      .i_req (bus.REQ),
      .i_ptr (r_ptr),
      .o_gnt (w_arb_gnt),
      .o_idx (w_arb_idx),
      .o_any (w_arb_any)
   );

   assign w_ptr_next  = (w_arb_idx == PW'(NREQ - 1)) ? '0 : w_arb_idx + 1'b1;
   assign w_req_g     = bus.REQ[r_gidx];
   assign w_din_g     = bus.DIN[int'(r_gidx) * WIDTH +: WIDTH];
   assign w_beat_next = r_beat + 1'b1;

   always_ff @(posedge CLK or posedge CLR) begin
      if (CLR) begin
         r_state    <= ST_IDLE;
         r_gnt      <= '0;
         r_gidx     <= '0;
         r_ptr      <= '0;
         r_beat     <= '0;
         r_turn     <= '0;
         r_pad_i    <= '0;
         r_pad_t    <= 1'b1;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_data  <= bus.PAD_O;
         r_rx_valid <= r_pad_t && (r_state == ST_IDLE);
         case (r_state)
            ST_IDLE: begin
               if (w_arb_any) begin
                  r_gnt   <= w_arb_gnt;
                  r_gidx  <= w_arb_idx;
                  r_ptr   <= w_ptr_next;
                  r_beat  <= '0;
                  r_state <= ST_DRIVE;
               end
            end
            ST_DRIVE: begin
               if (w_req_g) begin
                  r_pad_i <= w_din_g;
                  r_pad_t <= 1'b0;
                  r_beat  <= w_beat_next;
                  // Capped burst: the final word stays driven for one more cycle while TURN begins.
                  if (w_beat_next == BW'(MAXBURST)) begin
                     r_gnt   <= '0;
                     r_turn  <= TW'(TURN);
                     r_state <= ST_TURN;
                  end
               end else begin
                  r_pad_t <= 1'b1;
                  r_gnt   <= '0;
                  r_turn  <= TW'(TURN);
                  r_state <= ST_TURN;
               end
            end
            ST_TURN: begin
               r_pad_t <= 1'b1;
               if (r_turn == '0) begin
                  r_state <= ST_IDLE;
               end else begin
                  r_turn <= r_turn - 1'b1;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_gnt   <= '0;
               r_pad_t <= 1'b1;
            end
         endcase
      end
   end

   assign bus.GNT      = r_gnt;
   assign bus.PAD_I    = r_pad_i;
   assign bus.PAD_T    = r_pad_t;
   assign bus.RX_DATA  = r_rx_data;
   assign bus.RX_VALID = r_rx_valid;

endmodule

// File: tb/tb_iobuf_turnaround_ctrl.sv
// tb/tb_iobuf_turnaround_ctrl.sv - self-checking bench for iobuf_turnaround_ctrl
module tb_iobuf_turnaround_ctrl;
   localparam int WIDTH    = 8;
   localparam int NREQ     = 2;
   localparam int MAXBURST = 4;
   localparam int TURN     = 1;

   logic CLK;
   logic CLR;

   iobuf_turnaround_ctrl_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

   iobuf_turnaround_ctrl #(
      .WIDTH    (WIDTH),
      .NREQ     (NREQ),
      .MAXBURST (MAXBURST),
      .TURN     (TURN)
   ) dut (
      .CLK (CLK),
      .CLR (CLR),
      .bus (bus)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic [NREQ-1:0]  req;
      logic [WIDTH-1:0] din0;
      logic [WIDTH-1:0] pad_o;
      logic [NREQ-1:0]  gnt;
      logic             pad_t;
      logic [WIDTH-1:0] pad_i;
      logic             rx_valid;
   } vec_t;

   vec_t tbl [8];

   int total = 0;
   int bad   = 0;

   logic [WIDTH-1:0] q [NREQ][$];
   bit  use_q = 1'b0;
   int  cyc = 0;
   int  m_ptr = 0;
   int  last_beat = -1000;
   int  fall_cyc = -1000;
   int  burst_beats = 0;
   bit  have_beat = 1'b0;
   int  log_idx [$];
   int  log_len [$];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
      end
   endtask

   function automatic int rr_pick(input logic [NREQ-1:0] req, input int ptr);
      for (int k = 0; k < NREQ; k++) begin
         if (req[(ptr + k) % NREQ]) return (ptr + k) % NREQ;
      end
      return -1;
   endfunction

   task automatic drive_q();
      for (int i = 0; i < NREQ; i++) begin
         bus.REQ[i] = (q[i].size() != 0);
         bus.DIN[i*WIDTH +: WIDTH] = (q[i].size() != 0) ? q[i][0] : '0;
      end
   endtask

   task automatic reset_model();
      m_ptr       = 0;
      last_beat   = -1000;
      fall_cyc    = -1000;
      burst_beats = 0;
      have_beat   = 1'b0;
   endtask

   // One clock edge, then every rule that holds cycle by cycle.
   task automatic step();
      logic [NREQ-1:0]       p_gnt;
      logic [NREQ-1:0]       p_req;
      logic [NREQ*WIDTH-1:0] p_din;
      logic                  p_pad_t;
      logic [WIDTH-1:0]      p_pad_o;
      logic                  cons;
      int                    gi;
      int                    pick;
      p_gnt   = bus.GNT;
      p_req   = bus.REQ;
      p_din   = bus.DIN;
      p_pad_t = bus.PAD_T;
      p_pad_o = bus.PAD_O;
      @(posedge CLK);
      #1;
      cyc++;
      cons = |(p_gnt & p_req);
      gi = 0;
      for (int i = 0; i < NREQ; i++) if (p_gnt[i]) gi = i;
      chk("gnt_onehot", 32'($onehot0(bus.GNT)), 32'd1);
      chk("pad_t_vs_beat", 32'(bus.PAD_T), 32'(!cons));
      if (cons) begin
         chk("pad_i_word", 32'(bus.PAD_I), 32'(p_din[gi*WIDTH +: WIDTH]));
         if (burst_beats == 0 && have_beat)
            chk("turn_gap", 32'((cyc - last_beat) >= TURN + 2), 32'd1);
         burst_beats++;
         chk("burst_le_max", 32'(burst_beats <= MAXBURST), 32'd1);
         last_beat = cyc;
         have_beat = 1'b1;
         if (use_q) void'(q[gi].pop_front());
      end
      chk("rx_data", 32'(bus.RX_DATA), 32'(p_pad_o));
      if (bus.RX_VALID)
         chk("rx_valid_idle", 32'(p_gnt == '0 && p_pad_t), 32'd1);
      if (cyc > fall_cyc && cyc - fall_cyc <= TURN)
         chk("rx_valid_turn", 32'(bus.RX_VALID), 32'd0);
      if (p_gnt == '0 && bus.GNT != '0) begin
         pick = rr_pick(p_req, m_ptr);
         chk("rr_grant", 32'(bus.GNT), (pick >= 0) ? (32'd1 << pick) : 32'd0);
         if (pick >= 0) m_ptr = (pick + 1) % NREQ;
         burst_beats = 0;
      end
      if (p_gnt != '0 && bus.GNT != '0)
         chk("gnt_stable", 32'(bus.GNT), 32'(p_gnt));
      if (p_gnt != '0 && bus.GNT == '0) begin
         fall_cyc = cyc;
         log_idx.push_back(gi);
         log_len.push_back(burst_beats);
      end
      if (use_q) drive_q();
   endtask

   task automatic drain(input int budget);
      bit empty;
      for (int n = 0; n < budget; n++) begin
         empty = 1'b1;
         for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) empty = 1'b0;
         if (empty) break;
         step();
      end
      empty = 1'b1;
      for (int i = 0; i < NREQ; i++) if (q[i].size() != 0) empty = 1'b0;
      chk("drain_done", 32'(empty), 32'd1);
      repeat (TURN + 4) step();
   endtask

   task automatic check_log(input string nm, input int n, input int eidx [8], input int elen [8]);
      chk({nm, "_bursts"}, 32'(log_idx.size()), 32'(n));
      for (int k = 0; k < n && k < log_idx.size(); k++) begin
         chk({nm, "_idx"}, 32'(log_idx[k]), 32'(eidx[k]));
         chk({nm, "_len"}, 32'(log_len[k]), 32'(elen[k]));
      end
      log_idx.delete();
      log_len.delete();
   endtask

   initial begin
      bit seen;
      bus.REQ   = '0;
      bus.DIN   = '0;
      bus.PAD_O = 8'hFF;
      CLR       = 1'b1;

      // Reset values
      repeat (2) @(posedge CLK);
      #1;
      chk("rst_gnt", 32'(bus.GNT), 32'd0);
      chk("rst_pad_t", 32'(bus.PAD_T), 32'd1);
      chk("rst_pad_i", 32'(bus.PAD_I), 32'd0);
      chk("rst_rx_data", 32'(bus.RX_DATA), 32'd0);
      chk("rst_rx_valid", 32'(bus.RX_VALID), 32'd0);
      CLR = 1'b0;
      reset_model();

      // Single burst A1..A3 from requester 0, turnaround, then receive of 5C
      tbl[0] = '{2'b01, 8'hA1, 8'h11, 2'b01, 1'b1, 8'h00, 1'b1};
      tbl[1] = '{2'b01, 8'hA1, 8'h22, 2'b01, 1'b0, 8'hA1, 1'b0};
      tbl[2] = '{2'b01, 8'hA2, 8'h33, 2'b01, 1'b0, 8'hA2, 1'b0};
      tbl[3] = '{2'b01, 8'hA3, 8'h44, 2'b01, 1'b0, 8'hA3, 1'b0};
      tbl[4] = '{2'b00, 8'hA3, 8'h55, 2'b00, 1'b1, 8'hA3, 1'b0};
      tbl[5] = '{2'b00, 8'h00, 8'h66, 2'b00, 1'b1, 8'hA3, 1'b0};
      tbl[6] = '{2'b00, 8'h00, 8'h77, 2'b00, 1'b1, 8'hA3, 1'b0};
      tbl[7] = '{2'b00, 8'h00, 8'h5C, 2'b00, 1'b1, 8'hA3, 1'b1};
      for (int r = 0; r < 8; r++) begin
         bus.REQ              = tbl[r].req;
         bus.DIN              = '0;
         bus.DIN[WIDTH-1:0]   = tbl[r].din0;
         bus.PAD_O            = tbl[r].pad_o;
         step();
         chk($sformatf("vec%0d_gnt", r), 32'(bus.GNT), 32'(tbl[r].gnt));
         chk($sformatf("vec%0d_pad_t", r), 32'(bus.PAD_T), 32'(tbl[r].pad_t));
         chk($sformatf("vec%0d_pad_i", r), 32'(bus.PAD_I), 32'(tbl[r].pad_i));
         chk($sformatf("vec%0d_rx_valid", r), 32'(bus.RX_VALID), 32'(tbl[r].rx_valid));
         chk($sformatf("vec%0d_rx_data", r), 32'(bus.RX_DATA), 32'(tbl[r].pad_o));
      end
      log_idx.delete();
      log_len.delete();

      // MAXBURST cap: six words on requester 1 split as 4 + 2
      use_q = 1'b1;
      for (int w = 0; w < 6; w++) q[1].push_back(8'hB0 + 8'(w));
      drive_q();
      drain(80);
      check_log("cap", 2, '{1, 1, 0, 0, 0, 0, 0, 0}, '{4, 2, 0, 0, 0, 0, 0, 0});

      // Round-robin with both requesters continuously busy
      for (int w = 0; w < 8; w++) begin
         q[0].push_back(8'h10 + 8'(w));
         q[1].push_back(8'h20 + 8'(w));
      end
      drive_q();
      drain(120);
      check_log("rr", 4, '{0, 1, 0, 1, 0, 0, 0, 0}, '{4, 4, 4, 4, 0, 0, 0, 0});

      // REQ[0] falls on the same edge REQ[1] rises
      q[0].push_back(8'h31);
      q[0].push_back(8'h32);
      drive_q();
      seen = 1'b0;
      for (int n = 0; n < 20; n++) begin
         step();
         if (q[0].size() == 0) begin
            for (int w = 0; w < 3; w++) q[1].push_back(8'h40 + 8'(w));
            drive_q();
            seen = 1'b1;
            break;
         end
      end
      chk("simul_handoff", 32'(seen), 32'd1);
      drain(60);
      check_log("simul", 2, '{0, 1, 0, 0, 0, 0, 0, 0}, '{2, 3, 0, 0, 0, 0, 0, 0});

      // Randomized traffic against the rule-based model
      for (int n = 0; n < 400; n++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (q[i].size() == 0 && $urandom_range(0, 3) == 0) begin
               int cnt;
               cnt = $urandom_range(1, 6);
               for (int w = 0; w < cnt; w++) q[i].push_back(8'($urandom));
            end
         end
         bus.PAD_O = 8'($urandom);
         drive_q();
         step();
      end
      drain(200);
      log_idx.delete();
      log_len.delete();

      // Asynchronous clear in the middle of a driven burst
      for (int w = 0; w < 4; w++) q[0].push_back(8'hC0 + 8'(w));
      drive_q();
      for (int n = 0; n < 10; n++) begin
         step();
         if (bus.PAD_T == 1'b0) break;
      end
      chk("clr_precond_driving", 32'(bus.PAD_T), 32'd0);
      #2;
      CLR = 1'b1;
      #1;
      chk("clr_async_pad_t", 32'(bus.PAD_T), 32'd1);
      chk("clr_async_gnt", 32'(bus.GNT), 32'd0);
      chk("clr_async_rx_valid", 32'(bus.RX_VALID), 32'd0);
      @(posedge CLK);
      #1;
      CLR = 1'b0;
      reset_model();
      step();
      chk("clr_no_partial", 32'(bus.PAD_T), 32'd1);
      chk("clr_idle_after", 32'(bus.RX_VALID), 32'd1);
      drain(40);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
